// File: rtl/rgmii_tx_speed_adapt.sv
// rgmii_tx_speed_adapt: GMII-to-RGMII transmit adapter producing ODDR half-values for 10/100/1000M.
module rgmii_tx_speed_adapt #(
  parameter int unsigned DIV_100M  = 5,
  parameter int unsigned DIV_10M   = 50,
  parameter int unsigned BYTE_MODE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] mac_txd,
  input  logic       mac_tx_en,
  input  logic       mac_tx_er,
  output logic       mac_tx_clk_en,
  input  logic [1:0] speed,
  output logic [1:0] speed_active,
  output logic       tx_clk_d1,
  output logic       tx_clk_d2,
  output logic [3:0] txd_d1,
  output logic [3:0] txd_d2,
  output logic       tx_ctl_d1,
  output logic       tx_ctl_d2
);
  logic [1:0] spd_q, spd_d;
  logic [7:0] cnt_q, cnt_d, byte_q, byte_d, div, h;
  logic       phase_q, phase_d, cap_en_q, cap_en_d, cap_er_q, cap_er_d, bnd_q, bnd_d;
  logic       cen_q, cen_d, cer_q, cer_d;
  logic       clk1_q, clk1_d, clk2_q, clk2_d, ctl1_q, ctl1_d, ctl2_q, ctl2_d, clk_en_q, clk_en_d;
  logic [3:0] txd1_q, txd1_d, txd2_q, txd2_d;
  logic       adopt, gig, wrap, load, hi, ck_hi;
  always_comb begin
    adopt    = bnd_q && !cap_en_q && speed != spd_q;
    spd_d    = adopt ? speed : spd_q;
    gig      = spd_d[1];
    div      = spd_d[0] ? 8'(DIV_100M) : 8'(DIV_10M);
    h        = div >> 1;
    wrap     = cnt_q == div - 8'd1;
    cnt_d    = (adopt || gig || wrap) ? 8'd0 : cnt_q + 8'd1;
    // phase 1 marks the period carrying the high nibble; it ends with the capture strobe
    phase_d  = (adopt || gig) ? 1'b0 : wrap ? (!phase_q && BYTE_MODE != 0) : phase_q;
    byte_d   = clk_en_q ? mac_txd : byte_q;
    cap_en_d = clk_en_q ? mac_tx_en : cap_en_q;
    cap_er_d = clk_en_q ? mac_tx_er : cap_er_q;
    bnd_d    = clk_en_q;
    load     = !gig && cnt_d == h;
    hi       = phase_d && BYTE_MODE != 0;
    cen_d    = load ? cap_en_q : cen_q;
    cer_d    = load ? cap_er_q : cer_q;
    ck_hi    = cnt_d < h;
    clk1_d   = gig || ck_hi || (div[0] && cnt_d == h);
    clk2_d   = !gig && ck_hi;
    txd1_d   = gig ? mac_txd[3:0] : load ? (hi ? byte_q[7:4] : byte_q[3:0]) : txd1_q;
    txd2_d   = gig ? mac_txd[7:4] : txd1_d;
    ctl1_d   = gig ? mac_tx_en : ck_hi ? cen_d : cen_d ^ cer_d;
    ctl2_d   = gig ? mac_tx_en ^ mac_tx_er : ctl1_d;
    clk_en_d = gig || (cnt_d == div - 8'd1 && (phase_d || BYTE_MODE == 0));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      spd_q    <= 2'b10;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
      byte_q   <= '0;
      cap_en_q <= 1'b0;
      cap_er_q <= 1'b0;
      bnd_q    <= 1'b1;
      cen_q    <= 1'b0;
      cer_q    <= 1'b0;
      clk1_q   <= 1'b1;
      clk2_q   <= 1'b0;
      txd1_q   <= '0;
      txd2_q   <= '0;
      ctl1_q   <= 1'b0;
      ctl2_q   <= 1'b0;
      clk_en_q <= 1'b0;
    end else begin
      spd_q    <= spd_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      byte_q   <= byte_d;
      cap_en_q <= cap_en_d;
      cap_er_q <= cap_er_d;
      bnd_q    <= bnd_d;
      cen_q    <= cen_d;
      cer_q    <= cer_d;
      clk1_q   <= clk1_d;
      clk2_q   <= clk2_d;
      txd1_q   <= txd1_d;
      txd2_q   <= txd2_d;
      ctl1_q   <= ctl1_d;
      ctl2_q   <= ctl2_d;
      clk_en_q <= clk_en_d;
    end
  assign mac_tx_clk_en = clk_en_q;
  assign speed_active  = spd_q;
  assign tx_clk_d1     = clk1_q;
  assign tx_clk_d2     = clk2_q;
  assign txd_d1        = txd1_q;
  assign txd_d2        = txd2_q;
  assign tx_ctl_d1     = ctl1_q;
  assign tx_ctl_d2     = ctl2_q;
endmodule

// File: tb/tb_rgmii_tx_speed_adapt.sv
// tb_rgmii_tx_speed_adapt: directed checks of gigabit pass-through, 10/100 nibble timing, speed change and reset.
module tb_rgmii_tx_speed_adapt;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic [7:0] mac_txd = 8'h00;
  logic       mac_tx_en = 1'b0, mac_tx_er = 1'b0;
  logic [1:0] speed = 2'b10, speed_b = 2'b01;
  logic       a_clk_en, a_clk1, a_clk2, a_ctl1, a_ctl2;
  logic [3:0] a_txd1, a_txd2;
  logic [1:0] a_spd;
  logic       b_clk_en, b_clk1, b_clk2, b_ctl1, b_ctl2;
  logic [3:0] b_txd1, b_txd2;
  logic [1:0] b_spd;
  int n_run = 0, n_fail = 0;
  wire [14:0] a_vec = {a_clk1, a_clk2, a_txd1, a_txd2, a_ctl1, a_ctl2, a_clk_en, a_spd};
  wire [14:0] b_vec = {b_clk1, b_clk2, b_txd1, b_txd2, b_ctl1, b_ctl2, b_clk_en, b_spd};
  localparam logic [14:0] RST = {2'b10, 8'h00, 3'b000, 2'b10};
  always #5 clk = ~clk;
  rgmii_tx_speed_adapt u_a (
    .clk(clk), .rst_n(rst_n), .mac_txd(mac_txd), .mac_tx_en(mac_tx_en), .mac_tx_er(mac_tx_er),
    .mac_tx_clk_en(a_clk_en), .speed(speed), .speed_active(a_spd),
    .tx_clk_d1(a_clk1), .tx_clk_d2(a_clk2), .txd_d1(a_txd1), .txd_d2(a_txd2),
    .tx_ctl_d1(a_ctl1), .tx_ctl_d2(a_ctl2)
  );
  rgmii_tx_speed_adapt #(.DIV_100M(4), .DIV_10M(3), .BYTE_MODE(0)) u_b (
    .clk(clk), .rst_n(rst_n), .mac_txd(mac_txd), .mac_tx_en(mac_tx_en), .mac_tx_er(mac_tx_er),
    .mac_tx_clk_en(b_clk_en), .speed(speed_b), .speed_active(b_spd),
    .tx_clk_d1(b_clk1), .tx_clk_d2(b_clk2), .txd_d1(b_txd1), .txd_d2(b_txd2),
    .tx_ctl_d1(b_ctl1), .tx_ctl_d2(b_ctl2)
  );
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask
  // holds a byte on the bus until the strobe samples it, then returns just after that edge
  task automatic send(input logic [7:0] d, input logic e, input logic r);
    int n = 0;
    mac_txd = d;
    mac_tx_en = e;
    mac_tx_er = r;
    while (!a_clk_en && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("strobe_seen", 16'(a_clk_en), 16'(1));
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [3:0] nib;
    mac_txd = 8'hA5;
    mac_tx_en = 1'b1;
    @(negedge clk);
    chk("reset_a", 16'(a_vec), 16'(RST));
    chk("reset_b", 16'(b_vec), 16'(RST));
    rst_n = 1'b1;
    @(negedge clk);
    chk("gig_a5", 16'(a_vec), 16'({2'b10, 4'h5, 4'hA, 2'b11, 1'b1, 2'b10}));
    mac_txd = 8'h3C;
    mac_tx_er = 1'b1;
    @(negedge clk);
    chk("gig_er", 16'(a_vec), 16'({2'b10, 4'hC, 4'h3, 2'b10, 1'b1, 2'b10}));
    mac_txd = 8'h0F;
    mac_tx_en = 1'b0;
    @(negedge clk);
    chk("gig_ext", 16'(a_vec), 16'({2'b10, 4'hF, 4'h0, 2'b01, 1'b1, 2'b10}));
    speed = 2'b01;
    mac_tx_er = 1'b0;
    @(negedge clk);
    chk("adopt_100", 16'({a_spd, a_clk1, a_clk2, a_clk_en}), 16'({2'b01, 2'b11, 1'b0}));
    send(8'h21, 1'b1, 1'b0);
    mac_txd = 8'h43;
    for (int j = 0; j < 22; j++) begin
      @(negedge clk);
      if (j == 10) begin
        mac_txd = 8'h00;
        mac_tx_en = 1'b0;
      end
      chk("clk100", 16'({a_clk1, a_clk2}), 16'((j % 5 < 2) ? 2'b11 : (j % 5 == 2) ? 2'b10 : 2'b00));
      chk("stb100", 16'(a_clk_en), 16'(j % 10 == 9));
      if (j >= 2) begin
        nib = j < 7 ? 4'h1 : j < 12 ? 4'h2 : j < 17 ? 4'h3 : 4'h4;
        chk("nib100", 16'({a_txd1, a_txd2}), 16'({nib, nib}));
        chk("ctl100", 16'({a_ctl1, a_ctl2}), 16'(2'b11));
      end
    end
    speed = 2'b00;
    send(8'h65, 1'b1, 1'b0);
    @(negedge clk);
    chk("hold_frame", 16'(a_spd), 16'(2'b01));
    send(8'h00, 1'b0, 1'b0);
    @(negedge clk);
    chk("hold_bnd", 16'(a_spd), 16'(2'b01));
    @(negedge clk);
    chk("adopt_10", 16'({a_spd, a_clk1, a_clk2}), 16'({2'b00, 2'b11}));
    for (int m = 1; m <= 50; m++) begin
      @(negedge clk);
      chk("clk10", 16'({a_clk1, a_clk2}), 16'((m % 50 < 25) ? 2'b11 : 2'b00));
    end
    send(8'h87, 1'b1, 1'b1);
    mac_txd = 8'h00;
    mac_tx_en = 1'b0;
    mac_tx_er = 1'b0;
    for (int j = 0; j < 125; j++) begin
      @(negedge clk);
      chk("stb10", 16'(a_clk_en), 16'(j == 99));
      if (j >= 25) begin
        nib = j < 75 ? 4'h7 : 4'h8;
        chk("nib10", 16'({a_txd1, a_txd2}), 16'({nib, nib}));
        chk("ctl10_er", 16'({a_ctl1, a_ctl2}), 16'((j % 50 < 25) ? 2'b11 : 2'b00));
      end
    end
    speed = 2'b01;
    send(8'h00, 1'b0, 1'b0);
    @(negedge clk);
    chk("hold_10", 16'(a_spd), 16'(2'b00));
    @(negedge clk);
    chk("readopt", 16'(a_spd), 16'(2'b01));
    send(8'hCB, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_a", 16'(a_vec), 16'(RST));
    chk("async_rst_b", 16'(b_vec), 16'(RST));
    mac_txd = 8'h3C;
    mac_tx_en = 1'b1;
    mac_tx_er = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("post_rst_a", 16'({a_spd, a_clk1, a_clk2}), 16'({2'b01, 2'b11}));
        chk("post_rst_b", 16'(b_spd), 16'(2'b01));
      end
      chk("stb_rst", 16'(a_clk_en), 16'(k == 9));
      chk("b_stb", 16'(b_clk_en), 16'(k % 4 == 3));
      chk("b_clk", 16'({b_clk1, b_clk2}), 16'((k % 4 < 2) ? 2'b11 : 2'b00));
      if (k >= 2) begin
        chk("b_nib", 16'({b_txd1, b_txd2}), 16'(k < 6 ? 8'h00 : 8'hCC));
        chk("b_ctl", 16'({b_ctl1, b_ctl2}), 16'(k < 6 ? 2'b00 : 2'b11));
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/rgmii_tx_speed_adapt.md
RGMII_TX_SPEED_ADAPT -- requirements
Module: rgmii_tx_speed_adapt

Interface
REQ-001 SHALL have parameter DIV_100M, default 5: clk cycles per nibble period at 100M; legal range 2..255.
REQ-002 SHALL have parameter DIV_10M, default 50: clk cycles per nibble period at 10M; legal range 2..255.
REQ-003 SHALL have parameter BYTE_MODE, default 1: 1 = MAC supplies one byte per enable and the block sends low then high nibble; 0 = one nibble (mac_txd[3:0]) per enable.
REQ-004 SHALL have port clk, input, 1: the single clock (125 MHz); all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port mac_txd, input, 8: GMII transmit data.
REQ-007 SHALL have port mac_tx_en, input, 1: GMII transmit enable.
REQ-008 SHALL have port mac_tx_er, input, 1: GMII transmit error.
REQ-009 SHALL have port mac_tx_clk_en, output, 1: strobe; MAC data is sampled at the end of each cycle in which it is high.
REQ-010 SHALL have port speed, input, 2: requested speed; 00=10M, 01=100M, 1x=1000M.
REQ-011 SHALL have port speed_active, output, 2: speed currently in effect.
REQ-012 SHALL have ports tx_clk_d1 and tx_clk_d2, output, 1 each: rising-half and falling-half values for the TX clock ODDR.
REQ-013 SHALL have ports txd_d1 and txd_d2, output, 4 each, plus tx_ctl_d1 and tx_ctl_d2, output, 1 each: rising-half and falling-half values for the data/ctl ODDR.

Function
REQ-014 All outputs SHALL be registered; in 1000M, the d outputs SHALL reflect the MAC inputs with 1-cycle latency.
REQ-015 1000M: tx_clk_d1=1, tx_clk_d2=0, txd_d1=txd[3:0], txd_d2=txd[7:4], tx_ctl_d1=en, tx_ctl_d2=en^er, and mac_tx_clk_en SHALL be constantly 1.
REQ-016 10/100M: counter cnt SHALL run 0..DIV-1 and wrap to 0, where DIV is the divisor of the active speed and H=DIV>>1.
REQ-017 10/100M clock: for cnt<H, d1=d2=1; if DIV is odd and cnt==H, d1=1 and d2=0; otherwise d1=d2=0 (50% duty to half-cycle resolution).
REQ-018 10/100M nibble: a new nibble SHALL be presented at cnt==H and held for DIV cycles, with txd_d1=txd_d2=nibble.
REQ-019 10/100M ctl: while the clock is high (d2=1), ctl=en; while the clock is low, ctl=en^er, applied equally to d1 and d2 and using the en/er captured with the nibble's byte.
REQ-020 BYTE_MODE=1: mac_tx_clk_en SHALL pulse 1 cycle at cnt==DIV-1 in the period carrying the high nibble; the byte is captured into an internal byte register; its low nibble is presented at the next cnt==H and its high nibble one period later.
REQ-021 BYTE_MODE=0: mac_tx_clk_en SHALL pulse at every cnt==DIV-1, and mac_txd[3:0] SHALL be presented at the next cnt==H.
REQ-022 Speed change: a new speed value SHALL be adopted only at a byte boundary (the cycle after the capture strobe, or any cycle in 1000M) and only when the captured mac_tx_en=0; otherwise it is deferred until that condition holds.
REQ-023 On adoption of a new speed: speed_active updates, cnt=0, and the nibble phase resets to low; a speed input equal to speed_active SHALL cause no disturbance.
REQ-024 mac_tx_er with mac_tx_en=0 SHALL be passed through (carrier extension/error) as defined by the ctl equations; no other error handling.

Reset
REQ-025 While rst_n=0: tx_clk_d1=1, tx_clk_d2=0, txd_d*=0, tx_ctl_d*=0, mac_tx_clk_en=0, speed_active=2'b10, cnt=0, nibble phase=low, byte register=0.
REQ-026 After rst_n deasserts, the first adoption check SHALL occur in the first clock cycle; an assertion mid-frame SHALL abort the frame immediately.

Verification
REQ-027 speed=10 (1000M), txd=0xA5, en=1, er=0 -> next cycle: txd_d1=0x5, txd_d2=0xA, ctl_d1=1, ctl_d2=1, clk_en=1.
REQ-028 speed=01, DIV_100M=5 -> tx_clk (d1,d2) per cnt 0..4 = (1,1),(1,1),(1,0),(0,0),(0,0); clk_en pulses every 10 cycles.
REQ-029 100M, BYTE_MODE=1, bytes 0x21,0x43 with en=1 -> nibble sequence 1,2,3,4, each held 5 cycles; ctl=1 in both halves.
REQ-030 speed changed 01->00 mid-frame -> speed_active stays 01 until the first byte boundary with en=0, then becomes 00 with cnt=0; clock period becomes 50 cycles with high for 25.
REQ-031 10M, en=1, er=1 on one byte -> ctl=1 while the clock is high and 0 while it is low, for both nibbles of that byte.
REQ-032 rst_n pulsed low mid-frame at 100M -> all outputs equal their REQ-025 values asynchronously; after release, speed is re-adopted and the first clk_en occurs at cnt==4 of the second period.
